// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, A-source selects and
// controller state codes. Used by the control FSM and the datapath bench.
package cpu_pkg;

    localparam logic [2:0] opLoad  = 3'b000;
    localparam logic [2:0] opStore = 3'b001;
    localparam logic [2:0] opAdd   = 3'b010;
    localparam logic [2:0] opSub   = 3'b011;
    localparam logic [2:0] opIn    = 3'b100;
    localparam logic [2:0] opJz    = 3'b101;
    localparam logic [2:0] opJpos  = 3'b110;
    localparam logic [2:0] opHalt  = 3'b111;

    localparam logic [1:0] aselAlu   = 2'b00;
    localparam logic [1:0] aselInput = 2'b01;
    localparam logic [1:0] aselMem   = 2'b10;

    typedef enum logic [3:0] {
        sStart  = 4'd0,
        sFetch  = 4'd1,
        sDecode = 4'd2,
        sLoad   = 4'd3,
        sStore  = 4'd4,
        sAdd    = 4'd5,
        sSub    = 4'd6,
        sIn     = 4'd7,
        sJz     = 4'd8,
        sJpos   = 4'd9,
        sHalt   = 4'd10
    } stateT;

    // Execute state reached from DECODE for a given opcode.
    function automatic stateT opToState(input logic [2:0] op);
        stateT s;
        s = sStart;
        case (op)
            opLoad:  s = sLoad;
            opStore: s = sStore;
            opAdd:   s = sAdd;
            opSub:   s = sSub;
            opIn:    s = sIn;
            opJz:    s = sJz;
            opJpos:  s = sJpos;
            opHalt:  s = sHalt;
            default: s = sStart;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/enter_edge.sv
// Rising-edge detector for the Enter strobe. Reset preloads the history to 1
// so an Enter that is already high when reset releases never counts as a rise.
module enter_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic Enter,
    output logic rise
);

    logic enterPrev;

    always_ff @(posedge Clock) begin
        if (Reset) enterPrev <= 1'b1;
        else       enterPrev <= Enter;
    end

    assign rise = Enter & ~enterPrev;

endmodule

// File: rtl/control_fsm.sv
// Control sequencer for the 8-instruction accumulator CPU: FETCH, DECODE, one
// execute state per opcode, and a HALT state held until Reset.
module control_fsm
    import cpu_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       PCload,
    output logic       Aload,
    output logic       MemWr,
    output logic       JMPmux,
    output logic       Meminst,
    output logic       Sub,
    output logic [1:0] Asel,
    output logic       Halt,
    output logic [3:0] State
);

    stateT state;
    stateT nextState;
    logic  enterRise;

    enter_edge uEnterEdge (
        .Clock (Clock),
        .Reset (Reset),
        .Enter (Enter),
        .rise  (enterRise)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state <= sStart;
        else       state <= nextState;
    end

    always_comb begin
        nextState = sStart;
        IRload    = 1'b0;
        PCload    = 1'b0;
        Aload     = 1'b0;
        MemWr     = 1'b0;
        JMPmux    = 1'b0;
        Meminst   = 1'b0;
        Sub       = 1'b0;
        Asel      = aselAlu;
        Halt      = 1'b0;
        case (state)
            sStart: nextState = sFetch;
            sFetch: begin
                IRload    = 1'b1;
                PCload    = 1'b1;
                nextState = sDecode;
            end
            sDecode: begin
                Meminst   = 1'b1;
                nextState = opToState(IR);
            end
            sLoad: begin
                Meminst   = 1'b1;
                Asel      = aselMem;
                Aload     = 1'b1;
                nextState = sFetch;
            end
            sStore: begin
                Meminst   = 1'b1;
                MemWr     = 1'b1;
                nextState = sFetch;
            end
            sAdd, sSub: begin
                Meminst   = 1'b1;
                Sub       = (state == sSub);
                Aload     = 1'b1;
                nextState = sFetch;
            end
            // Wait here until a fresh Enter press; a level held from earlier is ignored.
            sIn: begin
                Asel      = aselInput;
                Aload     = enterRise;
                nextState = enterRise ? sFetch : sIn;
            end
            sJz: begin
                JMPmux    = 1'b1;
                PCload    = Aeq0;
                nextState = sFetch;
            end
            sJpos: begin
                JMPmux    = 1'b1;
                PCload    = Apos;
                nextState = sFetch;
            end
            sHalt: begin
                Halt      = 1'b1;
                nextState = sHalt;
            end
            default: nextState = sStart;
        endcase
        // Reset silences every output immediately, even mid-instruction.
        if (Reset) begin
            IRload  = 1'b0;
            PCload  = 1'b0;
            Aload   = 1'b0;
            MemWr   = 1'b0;
            JMPmux  = 1'b0;
            Meminst = 1'b0;
            Sub     = 1'b0;
            Asel    = aselAlu;
            Halt    = 1'b0;
        end
    end

    assign State = Reset ? 4'd0 : state;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameters SHALL be: none.
REQ-002 Clock  in  1  single system clock; all state updates SHALL occur on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 IR  in  3  opcode (instruction bits 7:5) from datapath.
REQ-005 Aeq0  in  1  accumulator == 0.
REQ-006 Apos  in  1  accumulator bit7 == 0.
REQ-007 Enter  in  1  user-input strobe; level, synchronous to Clock.
REQ-008 IRload, PCload, Aload, MemWr  out  1 each  register/memory write enables.
REQ-009 JMPmux  out  1  1 = PC next from IR[4:0], 0 = PC+1.
REQ-010 Meminst  out  1  1 = memory address from IR[4:0], 0 = from PC.
REQ-011 Sub  out  1  1 = subtract, 0 = add.
REQ-012 Asel  out  2  A source: 00 add/sub result, 01 INPUT, 10 memory data; 11 SHALL never be driven.
REQ-013 Halt  out  1  high while in HALT.
REQ-014 State  out  4  current state encoding, for debug display.

Function
REQ-015 Opcodes SHALL be: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 IN, 101 JZ, 110 JPOS, 111 HALT.
REQ-016 States SHALL be: START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, IN=7, JZ=8, JPOS=9, HALT=10; codes 11-15 SHALL transition to START.
REQ-017 Outputs SHALL be combinational from State (plus Enter/Aeq0/Apos where stated); every output not listed for a state SHALL be 0.
REQ-018 START: no outputs; next FETCH.
REQ-019 FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0; next DECODE.
REQ-020 DECODE: Meminst=1; next state selected by IR per REQ-015 (LOAD..HALT).
REQ-021 LOAD: Meminst=1, Asel=10, Aload=1; next FETCH.
REQ-022 STORE: Meminst=1, MemWr=1; next FETCH.
REQ-023 ADD: Meminst=1, Asel=00, Sub=0, Aload=1; next FETCH.
REQ-024 SUB: Meminst=1, Asel=00, Sub=1, Aload=1; next FETCH.
REQ-025 IN: Asel=01; Aload=1 only in the cycle that Enter rises (Enter=1 and previous-cycle Enter=0); next FETCH after that cycle, else remain in IN.
REQ-026 An Enter held high from before IN is entered SHALL NOT be consumed; a new 0->1 transition is required.
REQ-027 JZ: JMPmux=1, PCload=Aeq0; next FETCH.
REQ-028 JPOS: JMPmux=1, PCload=Apos; next FETCH.
REQ-029 HALT: Halt=1, all enables 0; remain until Reset.
REQ-030 Instruction latency SHALL be 3 cycles (FETCH, DECODE, execute), except IN, which is 3 cycles plus Enter wait.
REQ-031 At most one of IRload/Aload/MemWr SHALL be high in any cycle.

Reset
REQ-032 Reset=1 at a rising edge SHALL set State=START and clear the Enter-history flop to 1, so an Enter held through reset is not consumed.
REQ-033 While Reset=1, all outputs (incl. MemWr, PCload, Halt) SHALL be forced to 0 combinationally, including mid-instruction.
REQ-034 Reset SHALL override Enter, Aeq0 and Apos in the same cycle.

Structure
REQ-035 Opcode constants, Asel encodings and state encodings SHALL live in shared package cpu_pkg, used by control_fsm and the datapath bench.
REQ-036 Enter edge detection SHALL be one sub-module, enter_edge (1 flop + AND), output rise.
REQ-037 Target size: 120-400 RTL lines; no memories, no arithmetic beyond edge detect.

Verification
REQ-038 Reset, IR=000 -> START, FETCH (IRload=PCload=1), DECODE (Meminst=1), LOAD (Asel=10, Aload=1), FETCH.
REQ-039 IR=101, Aeq0=1 -> JZ cycle PCload=1, JMPmux=1; repeat with Aeq0=0 -> PCload=0, JMPmux=1.
REQ-040 IR=100, Enter=1 held before entry -> stays IN, Aload=0; Enter 0 then 1 -> single Aload=1 cycle, then FETCH.
REQ-041 IR=001, Reset asserted during the STORE cycle -> MemWr=0 in that cycle, State=START next edge.
REQ-042 IR=111 -> Halt=1, State=10 for 20 cycles, all enables 0; Reset -> START.
REQ-043 Random IR/Enter/Aeq0/Apos for 10k cycles -> REQ-031 holds and Asel!=11.
